// File: rtl/gcd_pkg.sv
// Shared types and encodings for the subtractive GCD controller.
package gcd_pkg;

   // Controller states, 3-bit encoding
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CALC  = 3'd1,
      STORE = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   // Subtractor operand order (Ss)
   localparam logic SUB_XY = 1'b0;
   localparam logic SUB_YX = 1'b1;

   // x/y register source select (Sx, Sy)
   localparam logic SEL_IN  = 1'b0;
   localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/gcd_controller_if.sv
// Host handshake plus datapath control/status bundle for the GCD controller.
interface gcd_controller_if #(
   parameter int ITER_W = 8
);
   logic              start;
   logic              abort;
   logic              xeqy;
   logic              xgty;
   logic              ldx;
   logic              ldy;
   logic              ldd;
   logic              Sx;
   logic              Sy;
   logic              Ss;
   logic              busy;
   logic              done;
   logic              err;
   logic [ITER_W-1:0] iter_cnt;

   // Environment side: host requests and datapath status
   modport master (
      output start, abort, xeqy, xgty,
      input  ldx, ldy, ldd, Sx, Sy, Ss, busy, done, err, iter_cnt
   );

   // Controller side
   modport slave (
      input  start, abort, xeqy, xgty,
      output ldx, ldy, ldd, Sx, Sy, Ss, busy, done, err, iter_cnt
   );
endinterface

// File: rtl/gcd_controller.sv
// Sequencer for the 8-bit subtractive GCD datapath: load, iterate, commit,
// with host abort and an iteration watchdog for zero-operand pairs.
module gcd_controller
   import gcd_pkg::*;
#(
   parameter int MAX_ITER = 255,
   parameter int ITER_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   gcd_controller_if.slave  bus
);

   localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

   state_t            state;
   logic [ITER_W-1:0] iter_q;
   logic              wdog_hit;

   // Watchdog only trips when the pair has not yet converged
   assign wdog_hit = (iter_q == MAX_CNT) && !bus.xeqy;

   // State register and iteration counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         iter_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= CALC;
                  iter_q <= '0;
               end
            end
            CALC: begin
               if (bus.abort)      state  <= IDLE;
               else if (bus.xeqy)  state  <= STORE;
               else if (wdog_hit)  state  <= ERR;
               else                iter_q <= iter_q + 1'b1;
            end
            STORE:   state <= bus.abort ? IDLE : DONE;
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Mealy decode of datapath controls; forced low while reset is held
   always_comb begin
      bus.ldx = 1'b0;
      bus.ldy = 1'b0;
      bus.ldd = 1'b0;
      bus.Sx  = SEL_IN;
      bus.Sy  = SEL_IN;
      bus.Ss  = SUB_XY;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.ldx = 1'b1;
                  bus.ldy = 1'b1;
               end
            end
            CALC: begin
               // one subtraction per cycle, larger operand minus smaller
               if (!bus.abort && !bus.xeqy && !wdog_hit) begin
                  if (bus.xgty) begin
                     bus.ldx = 1'b1;
                     bus.Sx  = SEL_SUB;
                     bus.Ss  = SUB_XY;
                  end else begin
                     bus.ldy = 1'b1;
                     bus.Sy  = SEL_SUB;
                     bus.Ss  = SUB_YX;
                  end
               end
            end
            STORE:   bus.ldd = !bus.abort;
            default: ;
         endcase
      end
   end

   // Host status comes from registered state only
   assign bus.busy     = (state != IDLE);
   assign bus.done     = (state == DONE) || (state == ERR);
   assign bus.err      = (state == ERR);
   assign bus.iter_cnt = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Self-checking bench: controller plus a behavioural datapath, checked
// against a Euclid-based reference for result, subtraction count and latency.
module tb_gcd_controller;

   localparam int MAX_ITER = 255;
   localparam int ITER_W   = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] x_i = '0, y_i = '0;
   logic [7:0] x = '0, y = '0, d = '0;
   int         n_cmp = 0, n_bad = 0;
   int         dual_ld = 0, ldd_cnt = 0, done_cnt = 0;

   gcd_controller_if #(.ITER_W(ITER_W)) bus();

   gcd_controller #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural datapath
   assign bus.xeqy = (x == y);
   assign bus.xgty = (x > y);
   always @(posedge clk) begin
      if (bus.ldx) x <= bus.Sx ? (bus.Ss ? y - x : x - y) : x_i;
      if (bus.ldy) y <= bus.Sy ? (bus.Ss ? y - x : x - y) : y_i;
      if (bus.ldd) d <= x;
   end

   // Protocol monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.busy && bus.ldx && bus.ldy) dual_ld++;
      if (bus.ldd)  ldd_cnt++;
      if (bus.done) done_cnt++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: Euclid division; subtractive step count = sum of quotients - 1
   task automatic ref_model(input int a, input int b,
                            output int g, output int n, output bit e);
      int p, q, r;
      e = 0; n = 0; g = 0;
      if (a == 0 && b == 0) begin
         g = 0;
      end else if (a == 0 || b == 0) begin
         e = 1;
         n = MAX_ITER;
      end else begin
         p = a; q = b;
         while (q != 0) begin
            n += p / q;
            r = p % q;
            p = q;
            q = r;
         end
         n -= 1;
         g = p;
      end
   endtask

   task automatic run_op(input int a, input int b, input bit noise);
      int g, n, cyc, exp_cyc, d0, l0;
      bit e, got;
      ref_model(a, b, g, n, e);
      exp_cyc = e ? MAX_ITER + 2 : n + 3;
      d0 = int'(d);
      l0 = ldd_cnt;
      @(negedge clk);
      x_i = 8'(a); y_i = 8'(b); bus.start = 1'b1;
      #1 chk("accept_ld", {bus.ldx, bus.ldy, bus.Sx, bus.Sy}, 4'b1100);
      cyc = 0; got = 0;
      while (!got && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            got = 1;
            bus.start = 1'b0;
         end else if (noise) begin
            bus.start = 1'($urandom_range(0, 1));
            x_i = 8'($urandom); y_i = 8'($urandom);
         end else begin
            bus.start = 1'b0;
         end
      end
      chk("done_seen", got, 1);
      chk("latency", cyc, exp_cyc);
      chk("err", bus.err, e);
      chk("iter_cnt", bus.iter_cnt, n);
      chk("d", d, e ? d0 : g);
      chk("ldd_count", ldd_cnt - l0, e ? 0 : 1);
      @(negedge clk);
      chk("idle_after", {bus.busy, bus.done}, 0);
   endtask

   // Cancel a 200/3 run in CALC cycle 'at', by abort or by reset
   task automatic run_cancel(input bit use_rst, input int at);
      int d0, l0, c0;
      d0 = int'(d);
      l0 = ldd_cnt;
      c0 = done_cnt;
      @(negedge clk);
      x_i = 8'd200; y_i = 8'd3; bus.start = 1'b1;
      for (int c = 1; c <= at; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      if (use_rst) begin
         rst_n = 1'b0; bus.start = 1'b1;
         #1 chk("rst_mid_ctl", {bus.ldx, bus.ldy, bus.ldd}, 0);
      end else begin
         bus.abort = 1'b1;
         #1 chk("abort_ctl", {bus.ldx, bus.ldy, bus.ldd}, 0);
      end
      @(negedge clk);
      bus.abort = 1'b0;
      chk("cancel_idle", {bus.busy, bus.done, bus.err}, 0);
      if (use_rst) chk("rst_iter", bus.iter_cnt, 0);
      rst_n = 1'b1; bus.start = 1'b0;
      repeat (5) @(negedge clk);
      chk("cancel_no_done", done_cnt - c0, 0);
      chk("cancel_no_ldd", ldd_cnt - l0, 0);
      chk("cancel_d", d, d0);
      run_op(12, 18, 0);
   endtask

   initial begin
      bus.start = 1'b1;
      bus.abort = 1'b0;
      x_i = 8'd12; y_i = 8'd18;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_outs", {bus.ldx, bus.ldy, bus.ldd, bus.Sx, bus.Sy, bus.Ss,
                       bus.busy, bus.done, bus.err}, 0);
      chk("rst_iter", bus.iter_cnt, 0);
      rst_n = 1'b1; bus.start = 1'b0;
      @(negedge clk);
      chk("idle_quiet", {bus.ldx, bus.ldy, bus.ldd, bus.busy}, 0);

      run_op(12, 18, 0);
      run_op(7, 7, 0);
      run_op(255, 1, 1);
      run_op(5, 0, 0);
      run_cancel(0, 10);
      run_cancel(1, 30);
      run_op(0, 0, 0);
      run_op(0, 9, 0);
      for (int i = 0; i < 10; i++)
         run_op(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), i[0]);

      chk("dual_load", dual_ld, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
FSM that sequences the 8-bit subtractive GCD datapath: loads operands, iterates conditional subtractions on the xeqy/xgty status, and commits the result to the d register. It exposes a start/busy/done handshake to the host and counts iterations. A watchdog aborts non-terminating operand pairs (zero operand) with an error flag. It sits beside the datapath inside a gcd_top wrapper, and all datapath control pins are driven only by this block.

Parameters:
MAX_ITER, 255, subtraction count at which the operation is aborted with err; legal range 1..2**ITER_W-1
ITER_W, 8, width of the iteration counter and of the iter_cnt output

Ports:
clk  in  1  rising-edge clock, shared with the datapath
rst_n  in  1  synchronous active-low reset
start  in  1  host request; accepted only in IDLE
abort  in  1  host cancel; effective in CALC and STORE
xeqy  in  1  datapath status x==y, combinational from registered x,y
xgty  in  1  datapath status x>y
ldx  out  1  datapath x load enable
ldy  out  1  datapath y load enable
ldd  out  1  datapath d load enable (d<=x)
Sx  out  1  x source: 0=x_i, 1=subtractor
Sy  out  1  y source: 0=y_i, 1=subtractor
Ss  out  1  subtractor order: 0=x-y, 1=y-x
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, operation finished (good or error)
err  out  1  valid with done; 1 = watchdog abort, d not updated
iter_cnt  out  ITER_W  subtractions performed in the last or current operation

Behaviour:
- States: IDLE, CALC, STORE, DONE, ERR. Reset (rst_n low at a clk edge) -> IDLE, iter_cnt=0. While in reset all control outputs are 0, and busy, done and err are 0.
- Control outputs are Mealy decodes of state, status and start. busy, done, err and iter_cnt are functions of registered state only.
- IDLE: if start=1, drive ldx=ldy=1 and Sx=Sy=0 in the same cycle. x_i and y_i must be valid in that cycle. Clear iter_cnt and go to CALC. If start=0, all control outputs are 0.
- CALC:
  - xeqy=1 -> go to STORE, no load.
  - xgty=1 -> drive ldx=1, Sx=1, Ss=0 (x<=x-y), iter_cnt+1.
  - otherwise -> drive ldy=1, Sy=1, Ss=1 (y<=y-x), iter_cnt+1.
  - Watchdog: if iter_cnt==MAX_ITER and xeqy=0, go to ERR with no load.
  - Exactly one subtraction per CALC cycle. Never assert ldx and ldy together outside IDLE.
- STORE: drive ldd=1 for one cycle, then go to DONE.
- DONE: done=1, err=0 for one cycle, then go to IDLE.
- ERR: done=1, err=1 for one cycle, then go to IDLE. ldd is never asserted on an error path.
- Latency: with the acceptance cycle = 0 and N subtractions, done is high in cycle N+3. d holds the GCD from cycle N+3.
- abort=1 in CALC or STORE -> IDLE next edge. No ldd, no done. abort has priority over ldd in STORE. abort is ignored in IDLE, DONE and ERR.
- start while busy=1 is ignored; no queuing. start in the DONE/ERR cycle is ignored; the host must re-assert it in IDLE.
- iter_cnt holds its value after the operation until the next accepted start. It never wraps, because the watchdog fires first.
- Boundary cases:
  - x=y=0 -> immediate STORE, d=0.
  - One operand 0, the other nonzero -> non-terminating, so err after MAX_ITER.

Decomposition:
- Package gcd_pkg holds:
  - the state enum (IDLE, CALC, STORE, DONE, ERR), 3-bit encoding;
  - the Ss encoding constants SUB_XY=0, SUB_YX=1;
  - the mux select constants SEL_IN=0, SEL_SUB=1.
- No sub-module. The state register, next-state/output decode and iteration counter stay in one module, about 150 lines.
- gcd_top instantiates gcd_controller and the datapath.

Test Plan:
- Reset with rst_n=0 for 2 cycles, start=1 held -> all outputs 0, iter_cnt=0, no loads.
- x_i=12, y_i=18, start pulse -> sequence y<=6 then x<=6; iter_cnt=2; done in cycle 5; err=0; d=6.
- x_i=7, y_i=7 -> no subtractions; done in cycle 3; d=7; iter_cnt=0.
- x_i=255, y_i=1 -> 254 iterations; done in cycle 257; d=1; err=0. start pulses during busy ignored (no reload).
- x_i=5, y_i=0, MAX_ITER=255 -> done=err=1 after 255 iterations; ldd never asserted; d keeps its prior value.
- x_i=200, y_i=3, abort in the 10th CALC cycle, then rst_n=0 mid-op on a second run -> IDLE next edge, no done, d unchanged.
- After each cancelled run, a fresh start of x_i=12, y_i=18 returns d=6.
